duty_button_ctrl: RTL
=====================

Name: duty_button_ctrl

Overview:
Front-panel input stage that sits directly upstream of the PWM generator. It synchronises and debounces two raw push-buttons, arbitrates between them, and emits the single-cycle duty_inc / duty_dec strobes the PWM block consumes. Optionally, holding a button produces auto-repeat strobes.

Parameters:
SYNC_STAGES, 2, synchroniser flops per button input (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes
REPEAT_DELAY, 1000, cycles from the first strobe to the first repeat strobe (auto-repeat only)
REPEAT_RATE, 250, cycles between subsequent repeat strobes (auto-repeat only)
CNT_W, 16, counter width; every count parameter must be < 2^CNT_W and >= 1

Ports:
clk  input  1  system clock, same domain as the PWM block
rst_n  input  1  asynchronous active-low reset
en  input  1  strobe enable; low suppresses strobes
btn_up  input  1  raw "increase" button, asynchronous, active-high
btn_dn  input  1  raw "decrease" button, asynchronous, active-high
duty_inc  output  1  one-cycle strobe to the PWM duty_inc input
duty_dec  output  1  one-cycle strobe to the PWM duty_dec input
up_db  output  1  debounced btn_up level
dn_db  output  1  debounced btn_dn level
locked  output  1  high while in the LOCK state

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, debounced levels, all counters = 0; FSM = IDLE; duty_inc = duty_dec = up_db = dn_db = locked = 0. All outputs are registered.
- Synchroniser: SYNC_STAGES-flop chain per button.
- Debounce (per button, always running, independent of en):
  - The counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- Press event: the debounced level rises 0->1. Release event: it falls 1->0.
- Latency: raw edge to strobe = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- FSM states are IDLE, HOLD_UP, HOLD_DN, LOCK:
  - IDLE:
    - up press with dn_db = 0 -> duty_inc = 1 for one cycle; go to HOLD_UP.
    - dn press with up_db = 0 -> duty_dec = 1 for one cycle; go to HOLD_DN.
    - Both press in the same cycle, or a press while the other button is already held -> LOCK, no strobe.
  - HOLD_UP: up release -> IDLE. dn press -> LOCK (no strobe).
  - HOLD_DN: mirror of HOLD_UP.
  - LOCK: locked = 1, no strobes. Exit to IDLE only when up_db = dn_db = 0.
- en = 0: the FSM is forced to IDLE and the repeat counter clears every cycle; strobes are 0.
  - A button already held when en rises does not strobe until it is released and pressed again, because a strobe requires a press event.
- duty_inc and duty_dec are never high in the same cycle.
- Strobes never occur on consecutive cycles when REPEAT_RATE >= 2.
- A mid-operation reset aborts immediately. The first post-reset strobe requires a full debounce of a fresh press.

Optional Feature:
Macro: DUTY_BTN_AUTO_REPEAT_EN
- Defined:
  - In HOLD_UP / HOLD_DN the repeat counter starts at 0 on the entry strobe and increments each cycle.
  - On reaching REPEAT_DELAY-1, the block re-issues the same strobe and reloads the counter for period REPEAT_RATE.
  - Thereafter the strobe repeats every REPEAT_RATE cycles until release, LOCK, en = 0, or reset.
  - Leaving the hold state clears the counter.
- Undefined: the repeat counter and its logic are absent; exactly one strobe per press. REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan:
Bench parameters: SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_RATE = 5.
1. Reset release, then btn_up held 30 cycles -> exactly one duty_inc pulse, 7 cycles after the raw edge; up_db = 1; duty_dec stays 0. Without the macro, no further pulses.
2. btn_dn glitches of 1, 2 and 3 cycles, separated by 10 low cycles -> dn_db stays 0, no duty_dec. A 4-cycle pulse -> dn_db = 1 and one duty_dec.
3. btn_up and btn_dn raised on the same clock, held 20 cycles -> locked = 1, no strobes. Release btn_up only -> still locked. Release btn_dn -> locked = 0 after debounce, FSM back in IDLE.
4. With the macro, btn_up held 60 cycles -> duty_inc at t0, t0+20, t0+25, t0+30, ... until release; nothing after up_db falls.
5. en = 0 while btn_dn is pressed and held, then en = 1 with the button still held -> no duty_dec. Release, then press again -> one duty_dec.
6. rst_n pulsed low for 1 cycle mid-hold (HOLD_UP, repeat counter at 10) -> all outputs 0 immediately (asynchronous). With btn_up still high, the debouncer re-qualifies the level and issues one fresh duty_inc 7 cycles after rst_n rises.

Source files
------------

// File: rtl/duty_button_ctrl.sv
// Button front end for the PWM block: sync, debounce and arbitrate two buttons into duty strobes.
// Define DUTY_BTN_AUTO_REPEAT_EN to add auto-repeat while a single button is held.
module duty_button_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_RATE     = 250,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn_up,
  input  logic btn_dn,
  output logic duty_inc,
  output logic duty_dec,
  output logic up_db,
  output logic dn_db,
  output logic locked
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      CNT_W < 1 || CNT_W > 31 || (64'(DEBOUNCE_CYCLES) >> CNT_W) != 0 ||
      (64'(REPEAT_DELAY) >> CNT_W) != 0 || (64'(REPEAT_RATE) >> CNT_W) != 0) begin : g_param_check
    $error("duty_button_ctrl: invalid parameter set");
  end

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHoldUp, StHoldDn, StLock} state_e;

  logic [SYNC_STAGES-1:0]   up_sync_q, dn_sync_q;
  logic [1:0]               sync_lvl;
  logic [1:0]               db_q, db_prev_q;
  logic [1:0][CNT_W-1:0]    db_cnt_q;
  logic [1:0]               press, rel;
  state_e                   state_q;
  logic                     inc_q, dec_q, locked_q;
  logic                     rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], btn_up};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], btn_dn};
    end
  end

  assign sync_lvl = {dn_sync_q[SYNC_STAGES-1], up_sync_q[SYNC_STAGES-1]};

  // Index 0 is the up button, index 1 the down button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;
  assign rel   = ~db_q & db_prev_q;

`ifdef DUTY_BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rep_cnt_q;
  logic             rep_phase_q;
  logic             hold_stay;

  // True exactly when the FSM will remain in a hold state this cycle.
  assign hold_stay = en && ((state_q == StHoldUp && !press[1] && !rel[0]) ||
                            (state_q == StHoldDn && !press[0] && !rel[1]));
  assign rep_fire  = rep_cnt_q == (rep_phase_q ? RateLast : DelayLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else if (hold_stay) begin
      if (rep_fire) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b1;
      end else begin
        rep_cnt_q   <= rep_cnt_q + 1'b1;
      end
    end else begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      if (!en) begin
        state_q  <= StIdle;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A press while the other button is down (or pressed together) is ambiguous.
            if ((press[0] && db_q[1]) || (press[1] && db_q[0])) begin
              state_q  <= StLock;
              locked_q <= 1'b1;
            end else if (press[0]) begin
              state_q <= StHoldUp;
              inc_q   <= 1'b1;
            end else if (press[1]) begin
              state_q <= StHoldDn;
              dec_q   <= 1'b1;
            end
          end
          StHoldUp: begin
            if (press[1]) begin
              state_q  <= StLock;
              locked_q <= 1'b1;
            end else if (rel[0]) begin
              state_q <= StIdle;
            end else if (rep_fire) begin
              inc_q <= 1'b1;
            end
          end
          StHoldDn: begin
            if (press[0]) begin
              state_q  <= StLock;
              locked_q <= 1'b1;
            end else if (rel[1]) begin
              state_q <= StIdle;
            end else if (rep_fire) begin
              dec_q <= 1'b1;
            end
          end
          StLock: begin
            if (!db_q[0] && !db_q[1]) begin
              state_q  <= StIdle;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_inc = inc_q;
  assign duty_dec = dec_q;
  assign up_db    = db_q[0];
  assign dn_db    = db_q[1];
  assign locked   = locked_q;

endmodule
